offset_mem_mp: RTL and testbench
================================

Name: offset_mem_mp

Overview:
Parametrised successor to the single-port offset memory model. It provides NRD independent read ports and one byte-strobed write port over an address window [OFFSET, OFFSET+DEPTH). Each read port is selectable sync or async. Out-of-window accesses are flagged. An optional post-reset clear sequencer zeroes the array and gates traffic until done. Used as the emulated memory primitive in mem tests and in small emulated SoCs.

Parameters:
WIDTH, 80, data width in bits (any value ≥1).
DEPTH, 32, number of entries (≥2).
OFFSET, 32, base address of the window. Index = addr − OFFSET.
AWIDTH, 6, address port width. OFFSET+DEPTH ≤ 2**AWIDTH.
NRD, 2, number of read ports (1..8).
SYNCREAD, 1, 1 = registered read (1-cycle latency), 0 = combinational read.
CLEAR_ON_RESET, 1, 1 = run clear sequencer after reset, 0 = array contents undefined after reset.
CLEAR_VAL, 0, WIDTH-bit value written to every entry by the sequencer.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ready  out  1  high when the array accepts traffic
ren  in  NRD  per-port read enable
raddr  in  NRD*AWIDTH  packed read addresses; port i at [i*AWIDTH +: AWIDTH]
rdata  out  NRD*WIDTH  packed read data
rvalid  out  NRD  read data valid, per port
rerr  out  NRD  read address out of window, per port
wen  in  1  write enable
waddr  in  AWIDTH  write address
wstrb  in  NB=ceil(WIDTH/8)  byte-lane write strobes; top lane may be partial
wdata  in  WIDTH  write data
werr  out  1  registered pulse: write address out of window

Behaviour:
- Window check: in_win(a) = (a ≥ OFFSET) && (a < OFFSET+DEPTH). Compute in AWIDTH+1 bits so the comparison never wraps.
- Reset (rst_n low, asynchronous):
  - With CLEAR_ON_RESET=1: FSM→CLEAR, clear index=0.
  - With CLEAR_ON_RESET=0: FSM→RUN.
  - Outputs forced: ready=0, rvalid=0, rerr=0, werr=0, and registered rdata=0 (SYNCREAD=1).
- FSM states:
  - CLEAR: write CLEAR_VAL to entry idx each cycle, idx++. At idx=DEPTH−1 → RUN on the next edge. ready=0 throughout.
  - RUN: ready=1. ready rises DEPTH cycles after rst_n deasserts with CLEAR_ON_RESET=1, or 1 cycle after with CLEAR_ON_RESET=0.
- Traffic while ready=0: user writes dropped, reads return rdata=0, rvalid=0, rerr=0, werr=0.
- Write, RUN state, wen=1:
  - In window: lane k of entry (waddr−OFFSET) updated iff wstrb[k]. The top lane covers only bits [WIDTH−1 : 8*(NB−1)].
  - Out of window: no update, werr=1 for exactly the following cycle.
  - wstrb=0 with wen=1: no update, no error.
- Read with SYNCREAD=1, port i:
  - ren[i]=1 at edge t: at t+1, rvalid[i]=1, rerr[i]=!in_win, and rdata = entry (or 0 if out of window).
  - ren[i]=0: rvalid[i]=0, rerr[i]=0, rdata holds its last value.
  - Same-cycle write to the same in-window address: write-first. Returned data = old word merged with the strobed new bytes.
- Read with SYNCREAD=0:
  - rdata, rvalid (= ren & ready & in_win) and rerr (= ren & ready & !in_win) are combinational from raddr.
  - A same-cycle write is not visible until after the edge.
- Multiple read ports at the same address are independent and return identical data.
- rst_n asserted mid-CLEAR or mid-RUN: immediate return to the reset state above. A partially cleared array is restarted from idx=0.

Decomposition:
- Package offset_mem_pkg holds:
  - state enum {ST_CLEAR, ST_RUN}
  - localparam function nbytes(WIDTH)
  - function in_win(addr, OFFSET, DEPTH)
  - lane mask generator function (handles the partial top lane)
- Sub-module offset_mem_rdport, instantiated NRD times by generate. It takes the array word, address, ren, ready and write-bypass info, and produces rdata/rvalid/rerr for both SYNCREAD modes.
- The top level holds the array, the write path and the clear FSM.

Test Plan:
- Clear: release rst_n with CLEAR_ON_RESET=1, CLEAR_VAL=80'hA5…A5 → ready rises exactly 32 cycles later. Reads of addr 32 and 63 return A5…A5 with rvalid=1, rerr=0.
- Write/read sync: write 80'h1234_5678_9ABC_DEF0_1122 to addr 40 with wstrb=10'h3FF. Next cycle read on both ports → both rdata equal the written word one cycle after ren.
- Byte strobes and bypass: entry 40 = all-ones. Write 0 to addr 40 with wstrb=10'h001 while port 0 reads addr 40 in the same cycle → rdata=80'hFF…FF00.
- Out of window: write to addr 31 → werr pulses one cycle and the array is unchanged. Read addr 64−1=63 → ok. Read addr 0 → rerr=1, rdata=0, rvalid=0.
- Async mode (SYNCREAD=0): change raddr each cycle → rdata tracks the array combinationally with zero latency, and a same-cycle write is seen only on the next cycle.
- Reset mid-clear: drop rst_n at idx=10 and release → ready=0 immediately, ready returns 32 cycles after release, and all entries read CLEAR_VAL.

Source files
------------

// File: rtl/offset_mem_pkg.sv
// offset_mem_pkg: shared types and helpers for the multi-port offset memory.
//   state_t    - clear sequencer states
//   nbytes     - number of byte lanes covering a word of a given width
//   in_win     - address window test [offset, offset+depth)
//   lane_mask  - expands byte strobes into a bit mask, clipping the top lane
package offset_mem_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Widest word lane_mask can describe; wider words are not supported.
    localparam int unsigned MAX_W  = 1024;
    localparam int unsigned MAX_NB = MAX_W / 8;

    function automatic int unsigned nbytes(input int unsigned w);
        return (w + 7) / 8;
    endfunction

    // Evaluated in 32 bits, which is wider than any address port plus one,
    // so offset + depth cannot wrap and the upper bound stays exact.
    function automatic logic in_win(input logic [31:0] addr,
                                    input logic [31:0] offset,
                                    input logic [31:0] depth);
        return (addr >= offset) && (addr < offset + depth);
    endfunction

    // Bit b is set when its byte lane is strobed and b lies inside the word;
    // this is what trims the partial top lane.
    function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_NB-1:0] strb,
                                                   input int unsigned       width);
        logic [MAX_W-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < MAX_W; b++) begin
            mask[b] = (b < width) && strb[b / 8];
        end
        return mask;
    endfunction

endpackage

// File: rtl/offset_mem_rdport.sv
// offset_mem_rdport: one read port of offset_mem_mp.
//   clk, rst_n       clock, asynchronous active-low reset
//   ready            array accepts traffic
//   ren, raddr       read enable and address
//   idx              entry index for the parent's array lookup (0 when out of window)
//   word             array word at idx, supplied by the parent
//   wr_fire, waddr,  write happening this cycle, its address and the merged
//   wr_word          word it will store (write-first bypass, registered mode only)
//   rdata, rvalid,   read data, valid and out-of-window error
//   rerr
// SYNCREAD=1 registers the result one cycle after ren; SYNCREAD=0 is
// purely combinational and ignores the write bypass.
module offset_mem_rdport
    import offset_mem_pkg::*;
#(
    parameter int unsigned WIDTH    = 80,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned OFFSET   = 32,
    parameter int unsigned AWIDTH   = 6,
    parameter int unsigned IW       = 5,
    parameter bit          SYNCREAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic              ren,
    input  logic [AWIDTH-1:0] raddr,
    output logic [IW-1:0]     idx,
    input  logic [WIDTH-1:0]  word,
    input  logic              wr_fire,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wr_word,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              rerr
);

    logic win;

    assign win = in_win(32'(raddr), OFFSET, DEPTH);
    assign idx = win ? IW'(32'(raddr) - OFFSET) : '0;

    if (SYNCREAD) begin : g_sync
        logic hit;

        // A write firing on the same edge to the same address is returned
        // as the merged new word, not the stale array contents.
        assign hit = wr_fire && (waddr == raddr);

        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata  <= '0;
                rvalid <= 1'b0;
                rerr   <= 1'b0;
            end else if (!ready) begin
                rdata  <= '0;
                rvalid <= 1'b0;
                rerr   <= 1'b0;
            end else if (ren) begin
                rdata  <= !win ? '0 : (hit ? wr_word : word);
                rvalid <= win;
                rerr   <= !win;
            end else begin
                // rdata deliberately holds its last value.
                rvalid <= 1'b0;
                rerr   <= 1'b0;
            end
        end
    end else begin : g_async
        logic unused_async;

        assign rvalid = ren && ready && win;
        assign rerr   = ren && ready && !win;
        assign rdata  = rvalid ? word : '0;

        assign unused_async = ^{clk, rst_n, wr_fire, waddr, wr_word};
    end

endmodule

// File: rtl/offset_mem_mp.sv
// offset_mem_mp: NRD-read / 1-write byte-strobed memory over the address
// window [OFFSET, OFFSET+DEPTH), with an optional post-reset clear sequencer.
//   clk, rst_n   clock, asynchronous active-low reset
//   ready        high once the array accepts traffic
//   ren          per-port read enables (NRD)
//   raddr        packed read addresses, port i at [i*AWIDTH +: AWIDTH]
//   rdata        packed read data, port i at [i*WIDTH +: WIDTH]
//   rvalid, rerr per-port read valid / out-of-window flags
//   wen, waddr   write enable and address
//   wstrb        byte-lane strobes (top lane may be partial)
//   wdata        write data
//   werr         one-cycle pulse after an out-of-window write
module offset_mem_mp
    import offset_mem_pkg::*;
#(
    parameter int unsigned     WIDTH          = 80,
    parameter int unsigned     DEPTH          = 32,
    parameter int unsigned     OFFSET         = 32,
    parameter int unsigned     AWIDTH         = 6,
    parameter int unsigned     NRD            = 2,
    parameter bit              SYNCREAD       = 1'b1,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VAL     = '0,
    localparam int unsigned    NB             = nbytes(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [NRD-1:0]          ren,
    input  logic [NRD*AWIDTH-1:0]   raddr,
    output logic [NRD*WIDTH-1:0]    rdata,
    output logic [NRD-1:0]          rvalid,
    output logic [NRD-1:0]          rerr,
    input  logic                    wen,
    input  logic [AWIDTH-1:0]       waddr,
    input  logic [NB-1:0]           wstrb,
    input  logic [WIDTH-1:0]        wdata,
    output logic                    werr
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam state_t      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    logic [WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    state_t        state, state_next;
    logic [IW-1:0] clr_idx, clr_idx_next;
    logic          clr_we;
    logic          ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
            // Registered so ready is low in the first cycle even when the
            // sequencer is disabled and the FSM resets straight into RUN.
            ready_q <= (state_next == ST_RUN);
        end
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        clr_we       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == IW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    clr_idx_next = clr_idx + 1'b1;
                end
            end
            ST_RUN: begin
            end
            default: state_next = ST_RESET;
        endcase
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic              wwin;
    logic [IW-1:0]     widx;
    logic [MAX_NB-1:0] strb_ext;
    logic [WIDTH-1:0]  wmask;
    logic [WIDTH-1:0]  wr_word;
    logic              wr_fire;

    assign wwin     = in_win(32'(waddr), OFFSET, DEPTH);
    assign widx     = wwin ? IW'(32'(waddr) - OFFSET) : '0;
    assign strb_ext = MAX_NB'(wstrb);
    assign wmask    = WIDTH'(lane_mask(strb_ext, WIDTH));
    assign wr_word  = (mem[widx] & ~wmask) | (wdata & wmask);
    assign wr_fire  = ready_q && wen && wwin && (|wstrb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            werr <= 1'b0;
        end else begin
            werr <= ready_q && wen && !wwin;
        end
    end

    // NOTE: the array has no reset; initialisation is the clear sequencer's
    // job, which keeps the storage mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= CLEAR_VAL;
        end else if (wr_fire) begin
            mem[widx] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [IW-1:0]    ridx  [NRD];
    logic [WIDTH-1:0] rword [NRD];

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rword[g] = mem[ridx[g]];

        offset_mem_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .OFFSET   (OFFSET),
            .AWIDTH   (AWIDTH),
            .IW       (IW),
            .SYNCREAD (SYNCREAD)
        ) u_rdport (
            .clk     (clk),
            .rst_n   (rst_n),
            .ready   (ready_q),
            .ren     (ren[g]),
            .raddr   (raddr[g*AWIDTH +: AWIDTH]),
            .idx     (ridx[g]),
            .word    (rword[g]),
            .wr_fire (wr_fire),
            .waddr   (waddr),
            .wr_word (wr_word),
            .rdata   (rdata[g*WIDTH +: WIDTH]),
            .rvalid  (rvalid[g]),
            .rerr    (rerr[g])
        );
    end

endmodule

// File: tb/tb_offset_mem_mp.sv
// Directed bench for offset_mem_mp. Two instances share all inputs: u_sync
// (SYNCREAD=1) and u_async (SYNCREAD=0), both clearing to A5..A5 on reset.
module tb_offset_mem_mp;

    localparam int unsigned W   = 80;
    localparam int unsigned AW  = 6;
    localparam int unsigned NRD = 2;
    localparam int unsigned NB  = 10;

    localparam logic [W-1:0] CV   = {10{8'hA5}};
    localparam logic [W-1:0] WD   = 80'h1234_5678_9ABC_DEF0_1122;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] LOW0 = 80'hFFFF_FFFF_FFFF_FFFF_FF00;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRD-1:0]    ren   = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic              wen   = 1'b0;
    logic [AW-1:0]     waddr = '0;
    logic [NB-1:0]     wstrb = '0;
    logic [W-1:0]      wdata = '0;

    logic              ready_s, ready_a, werr_s, werr_a;
    logic [NRD*W-1:0]  rdata_s, rdata_a;
    logic [NRD-1:0]    rvalid_s, rvalid_a, rerr_s, rerr_a;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    offset_mem_mp #(
        .WIDTH(W), .DEPTH(32), .OFFSET(32), .AWIDTH(AW), .NRD(NRD),
        .SYNCREAD(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CV)
    ) u_sync (
        .clk(clk), .rst_n(rst_n), .ready(ready_s), .ren(ren), .raddr(raddr),
        .rdata(rdata_s), .rvalid(rvalid_s), .rerr(rerr_s), .wen(wen),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .werr(werr_s)
    );

    offset_mem_mp #(
        .WIDTH(W), .DEPTH(32), .OFFSET(32), .AWIDTH(AW), .NRD(NRD),
        .SYNCREAD(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CV)
    ) u_async (
        .clk(clk), .rst_n(rst_n), .ready(ready_a), .ren(ren), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a), .rerr(rerr_a), .wen(wen),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .werr(werr_a)
    );

    function automatic logic [W-1:0] pd(input logic [NRD*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ren = '0; raddr = '0; wen = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
    endtask

    // Counts edges after rst_n release until ready_s rises (bounded).
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_s && n < 100) begin
            tick();
            n++;
        end
        n_total++; if (n !== 32) $display("FAIL %s_latency: got %0d cycles want 32", tag, n); else n_pass++;
        n_total++; if (ready_a !== 1'b1) $display("FAIL %s_ready_a: got %b want 1", tag, ready_a); else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        ren = 2'b11; raddr = {6'd33, 6'd32};
        #1;
        n_total++; if (ready_s !== 1'b0) $display("FAIL reset_ready_s: got %b want 0", ready_s); else n_pass++;
        n_total++; if (ready_a !== 1'b0) $display("FAIL reset_ready_a: got %b want 0", ready_a); else n_pass++;
        n_total++; if (rvalid_s !== 2'b00 || rerr_s !== 2'b00) $display("FAIL reset_flags_s: got v=%b e=%b want 00/00", rvalid_s, rerr_s); else n_pass++;
        n_total++; if (rvalid_a !== 2'b00 || rerr_a !== 2'b00) $display("FAIL reset_flags_a: got v=%b e=%b want 00/00", rvalid_a, rerr_a); else n_pass++;
        n_total++; if (rdata_s !== '0 || rdata_a !== '0) $display("FAIL reset_rdata: got s=%h a=%h want 0", rdata_s, rdata_a); else n_pass++;
        n_total++; if (werr_s !== 1'b0 || werr_a !== 1'b0) $display("FAIL reset_werr: got %b%b want 00", werr_s, werr_a); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_clear();
        rst_n = 1'b1;
        wait_ready("clear");
        ren = 2'b11; raddr = {6'd63, 6'd32};
        #1;
        n_total++; if (rdata_a !== {CV, CV}) $display("FAIL clear_rdata_a: got %h want %h", rdata_a, {CV, CV}); else n_pass++;
        n_total++; if (rvalid_a !== 2'b11 || rerr_a !== 2'b00) $display("FAIL clear_flags_a: got v=%b e=%b want 11/00", rvalid_a, rerr_a); else n_pass++;
        tick();
        n_total++; if (rdata_s !== {CV, CV}) $display("FAIL clear_rdata_s: got %h want %h", rdata_s, {CV, CV}); else n_pass++;
        n_total++; if (rvalid_s !== 2'b11 || rerr_s !== 2'b00) $display("FAIL clear_flags_s: got v=%b e=%b want 11/00", rvalid_s, rerr_s); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_write_read();
        wen = 1'b1; waddr = 6'd40; wstrb = 10'h3FF; wdata = WD;
        tick();
        idle_inputs();
        ren = 2'b11; raddr = {6'd40, 6'd40};
        #1;
        // ren was low on the last edge: sync data holds, valid drops.
        n_total++; if (rvalid_s !== 2'b00) $display("FAIL hold_rvalid_s: got %b want 00", rvalid_s); else n_pass++;
        n_total++; if (rdata_s !== {CV, CV}) $display("FAIL hold_rdata_s: got %h want %h", rdata_s, {CV, CV}); else n_pass++;
        n_total++; if (rdata_a !== {WD, WD}) $display("FAIL wr_rdata_a: got %h want %h", rdata_a, {WD, WD}); else n_pass++;
        tick();
        n_total++; if (rdata_s !== {WD, WD}) $display("FAIL wr_rdata_s: got %h want %h", rdata_s, {WD, WD}); else n_pass++;
        n_total++; if (rvalid_s !== 2'b11) $display("FAIL wr_rvalid_s: got %b want 11", rvalid_s); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_strobe_bypass();
        wen = 1'b1; waddr = 6'd40; wstrb = 10'h3FF; wdata = ONES;
        tick();
        wen = 1'b1; waddr = 6'd40; wstrb = 10'h001; wdata = '0;
        ren = 2'b01; raddr = {6'd40, 6'd40};
        #1;
        n_total++; if (pd(rdata_a, 0) !== ONES) $display("FAIL byp_pre_a: got %h want %h", pd(rdata_a, 0), ONES); else n_pass++;
        tick();
        wen = 1'b0; wstrb = '0;
        #1;
        n_total++; if (pd(rdata_s, 0) !== LOW0) $display("FAIL byp_rdata_s: got %h want %h", pd(rdata_s, 0), LOW0); else n_pass++;
        n_total++; if (rvalid_s !== 2'b01) $display("FAIL byp_rvalid_s: got %b want 01", rvalid_s); else n_pass++;
        n_total++; if (pd(rdata_a, 0) !== LOW0) $display("FAIL byp_post_a: got %h want %h", pd(rdata_a, 0), LOW0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_out_of_window();
        wen = 1'b1; waddr = 6'd31; wstrb = 10'h3FF; wdata = '0;
        tick();
        wen = 1'b0; wstrb = '0;
        #1;
        n_total++; if (werr_s !== 1'b1 || werr_a !== 1'b1) $display("FAIL oow_werr: got %b%b want 11", werr_s, werr_a); else n_pass++;
        tick();
        n_total++; if (werr_s !== 1'b0 || werr_a !== 1'b0) $display("FAIL oow_werr_pulse: got %b%b want 00", werr_s, werr_a); else n_pass++;
        // Port 0 reads the last entry (where a wrapped index would land),
        // port 1 reads address 0.
        ren = 2'b11; raddr = {6'd0, 6'd63};
        #1;
        n_total++; if (rvalid_a !== 2'b01 || rerr_a !== 2'b10) $display("FAIL oow_flags_a: got v=%b e=%b want 01/10", rvalid_a, rerr_a); else n_pass++;
        n_total++; if (rdata_a !== {{W{1'b0}}, CV}) $display("FAIL oow_rdata_a: got %h want %h", rdata_a, {{W{1'b0}}, CV}); else n_pass++;
        tick();
        n_total++; if (rvalid_s !== 2'b01 || rerr_s !== 2'b10) $display("FAIL oow_flags_s: got v=%b e=%b want 01/10", rvalid_s, rerr_s); else n_pass++;
        n_total++; if (rdata_s !== {{W{1'b0}}, CV}) $display("FAIL oow_rdata_s: got %h want %h", rdata_s, {{W{1'b0}}, CV}); else n_pass++;
        // Zero strobes: no update and no error.
        idle_inputs();
        wen = 1'b1; waddr = 6'd33; wstrb = 10'h000; wdata = '0;
        tick();
        idle_inputs();
        ren = 2'b11; raddr = {6'd33, 6'd32};
        #1;
        n_total++; if (werr_s !== 1'b0) $display("FAIL strb0_werr: got %b want 0", werr_s); else n_pass++;
        tick();
        n_total++; if (rdata_s !== {CV, CV}) $display("FAIL strb0_rdata_s: got %h want %h", rdata_s, {CV, CV}); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_async();
        logic [AW-1:0] a_tab [3];
        logic [W-1:0]  e_tab [3];
        a_tab[0] = 6'd32; e_tab[0] = CV;
        a_tab[1] = 6'd40; e_tab[1] = LOW0;
        a_tab[2] = 6'd63; e_tab[2] = CV;
        ren = 2'b01;
        for (int i = 0; i < 3; i++) begin
            raddr = {6'd0, a_tab[i]};
            #1;
            n_total++; if (pd(rdata_a, 0) !== e_tab[i]) $display("FAIL async_track%0d: got %h want %h", i, pd(rdata_a, 0), e_tab[i]); else n_pass++;
            tick();
        end
        wen = 1'b1; waddr = 6'd34; wstrb = 10'h3FF; wdata = WD;
        raddr = {6'd0, 6'd34};
        #1;
        n_total++; if (pd(rdata_a, 0) !== CV) $display("FAIL async_samecyc: got %h want %h", pd(rdata_a, 0), CV); else n_pass++;
        tick();
        wen = 1'b0; wstrb = '0;
        #1;
        n_total++; if (pd(rdata_a, 0) !== WD) $display("FAIL async_after: got %h want %h", pd(rdata_a, 0), WD); else n_pass++;
        n_total++; if (pd(rdata_s, 0) !== WD) $display("FAIL sync_wfirst: got %h want %h", pd(rdata_s, 0), WD); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        // Reset from RUN: ready and registered data drop at once.
        rst_n = 1'b0;
        #1;
        n_total++; if (ready_s !== 1'b0 || ready_a !== 1'b0) $display("FAIL midrun_ready: got %b%b want 00", ready_s, ready_a); else n_pass++;
        n_total++; if (rdata_s !== '0) $display("FAIL midrun_rdata_s: got %h want 0", rdata_s); else n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        n_total++; if (ready_s !== 1'b0) $display("FAIL midclr_ready: got %b want 0", ready_s); else n_pass++;
        tick();
        rst_n = 1'b1;
        wait_ready("midclr");
        for (int k = 0; k < 16; k++) begin
            ren = 2'b11;
            raddr = {6'(33 + 2 * k), 6'(32 + 2 * k)};
            tick();
            n_total++; if (rdata_s !== {CV, CV}) $display("FAIL midclr_entry%0d: got %h want %h", 2 * k, rdata_s, {CV, CV}); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_strobe_bypass();
        test_out_of_window();
        test_async();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
